// File: rtl/param_learning_neuron_if.sv
// Handshake bundle for param_learning_neuron: input vector, activation,
// error feedback, upstream error terms, weight load and status.
interface param_learning_neuron_if #(
  parameter int N_INPUTS = 32,
  parameter int DATA_W   = 32
);
  localparam int AW = $clog2(N_INPUTS + 1);

  logic                       in_valid;
  logic                       in_ready;
  logic [N_INPUTS*DATA_W-1:0] in_data;
  logic                       learn_en;

  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          out_data;

  logic                       err_valid;
  logic                       err_ready;
  logic [DATA_W-1:0]          err_data;
  logic [DATA_W-1:0]          lr;

  logic                       back_valid;
  logic [N_INPUTS*DATA_W-1:0] back_data;

  logic                       wload;
  logic [AW-1:0]              wload_addr;
  logic [DATA_W-1:0]          wload_data;

  logic                       busy;

  modport master (
    output in_valid, in_data, learn_en,
    output out_ready,
    output err_valid, err_data, lr,
    output wload, wload_addr, wload_data,
    input  in_ready, out_valid, out_data,
    input  err_ready, back_valid, back_data,
    input  busy
  );

  modport slave (
    input  in_valid, in_data, learn_en,
    input  out_ready,
    input  err_valid, err_data, lr,
    input  wload, wload_addr, wload_data,
    output in_ready, out_valid, out_data,
    output err_ready, back_valid, back_data,
    output busy
  );
endinterface

// File: rtl/param_learning_neuron.sv
// Sequential learning neuron: one MAC per cycle forward, ReLU, optional backprop.
// Define NEURON_SAT_EN to saturate instead of wrap on every narrowing to DATA_W.
module param_learning_neuron #(
  parameter int N_INPUTS = 32,
  parameter int DATA_W   = 32,
  parameter int FRAC_W   = 0,
  parameter int INIT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  param_learning_neuron_if.slave bus
);

  localparam int IW  = $clog2(N_INPUTS + 1);
  localparam int DW2 = 2 * DATA_W;
  localparam int WW  = 4 * DATA_W;

  typedef logic signed [DATA_W-1:0] word_t;
  typedef logic signed [DW2-1:0]    dword_t;
  typedef logic signed [WW-1:0]     wide_t;

  localparam word_t ONE  = word_t'(1 <<< FRAC_W);
  localparam word_t INIT = word_t'(INIT_W);

`ifdef NEURON_SAT_EN
  localparam word_t DMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam word_t DMIN = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FWD,
    S_OUT,
    S_WAIT,
    S_BWD
  } state_t;

  function automatic dword_t ext2(input word_t v);
    return {{DATA_W{v[DATA_W-1]}}, v};
  endfunction

  function automatic wide_t wext(input dword_t v);
    return {{(WW-DW2){v[DW2-1]}}, v};
  endfunction

  function automatic wide_t wext1(input word_t v);
    return {{(WW-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic word_t fit(input wide_t v);
`ifdef NEURON_SAT_EN
    if (v > wext1(DMAX)) return DMAX;
    if (v < wext1(DMIN)) return DMIN;
`endif
    return v[DATA_W-1:0];
  endfunction

  state_t state, state_n;

  logic [IW-1:0] idx;
  logic          last;
  logic          learn;
  logic          relu_active;
  logic          out_valid_q;
  logic          back_valid_q;

  word_t  w    [N_INPUTS+1];
  word_t  x    [N_INPUTS];
  word_t  xe   [N_INPUTS+1];
  word_t  back [N_INPUTS];
  word_t  delta;
  word_t  lr_q;
  word_t  out_q;
  dword_t acc;

  dword_t fprod;
  dword_t acc_nxt;
  dword_t bprod;
  dword_t step;
  wide_t  upd;
  wide_t  wnew;
  word_t  back_nxt;
  word_t  w_nxt;
  word_t  relu_nxt;

  assign last = (idx == IW'(N_INPUTS));

  // Bias sits at index N_INPUTS with a constant 1.0 input.
  always_comb begin
    for (int i = 0; i < N_INPUTS; i++) xe[i] = x[i];
    xe[N_INPUTS] = ONE;
  end

  always_comb begin
    fprod    = ext2(w[idx]) * ext2(xe[idx]);
    acc_nxt  = acc + (fprod >>> FRAC_W);
    bprod    = ext2(delta) * ext2(w[idx]);
    back_nxt = fit(wext(bprod >>> FRAC_W));
    step     = (ext2(lr_q) * ext2(delta)) >>> FRAC_W;
    upd      = (wext(step) * wext1(xe[idx])) >>> FRAC_W;
    wnew     = wext1(w[idx]) - upd;
    w_nxt    = fit(wnew);
    relu_nxt = acc[DW2-1] ? '0 : fit(wext(acc));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (bus.in_valid) state_n = S_FWD;
      S_FWD:  if (last) state_n = S_OUT;
      S_OUT: begin
        if (out_valid_q && bus.out_ready)
          state_n = learn ? S_WAIT : S_IDLE;
      end
      S_WAIT: if (bus.err_valid) state_n = S_BWD;
      S_BWD:  if (last) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= N_INPUTS; i++) w[i] <= INIT;
      for (int i = 0; i < N_INPUTS; i++) begin
        x[i]    <= '0;
        back[i] <= '0;
      end
      idx          <= '0;
      acc          <= '0;
      learn        <= 1'b0;
      relu_active  <= 1'b0;
      delta        <= '0;
      lr_q         <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      back_valid_q <= 1'b0;
    end else begin
      back_valid_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.wload) begin
            for (int i = 0; i <= N_INPUTS; i++)
              if (bus.wload_addr == IW'(i)) w[i] <= bus.wload_data;
          end
          if (bus.in_valid) begin
            for (int i = 0; i < N_INPUTS; i++)
              x[i] <= bus.in_data[i*DATA_W +: DATA_W];
            learn <= bus.learn_en;
            acc   <= '0;
            idx   <= '0;
          end
        end
        S_FWD: begin
          acc <= acc_nxt;
          idx <= last ? '0 : idx + 1'b1;
        end
        S_OUT: begin
          // First OUT cycle registers the activation; valid then holds.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_q       <= relu_nxt;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            relu_active <= !acc[DW2-1] && (acc != '0);
          end
        end
        S_WAIT: begin
          if (bus.err_valid) begin
            delta <= relu_active ? word_t'(bus.err_data) : '0;
            lr_q  <= bus.lr;
            idx   <= '0;
          end
        end
        S_BWD: begin
          for (int i = 0; i < N_INPUTS; i++)
            if (idx == IW'(i)) back[i] <= back_nxt;
          for (int i = 0; i <= N_INPUTS; i++)
            if (idx == IW'(i)) w[i] <= w_nxt;
          idx <= last ? '0 : idx + 1'b1;
          if (last) back_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (state == S_IDLE);
  assign bus.err_ready  = (state == S_WAIT);
  assign bus.busy       = (state != S_IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_q;
  assign bus.back_valid = back_valid_q;

  for (genvar g = 0; g < N_INPUTS; g++) begin : g_back
    assign bus.back_data[g*DATA_W +: DATA_W] = back[g];
  end

endmodule
